// File: rtl/dbuf_pkg.sv
// Shared constants, state type and range helper for the dbuf loader.
// Optional checksum port is enabled by defining DBUF_LOAD_CSUM_EN.
package dbuf_pkg;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 49152;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        READY
    } ld_state_t;

    // One extra bit on the sum so base+len never wraps before the compare.
    function automatic logic load_fits(input logic [AW-1:0] first, input logic [AW-1:0] count);
        logic [AW:0] end_ex;
        logic [AW:0] limit;
        end_ex = {1'b0, first} + {1'b0, count};
        limit  = DEPTH[AW:0];
        return end_ex <= limit;
    endfunction

endpackage

// File: rtl/dbuf_loader_if.sv
// Stream input and dbuf write/read port of the loader, bundled as one interface.
// The slave modport is the loader's view; master is the surrounding environment.
interface dbuf_loader_if;
    import dbuf_pkg::*;

    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;

    logic [DW-1:0] buf_din;
    logic [AW-1:0] buf_didx;
    logic          buf_rw;
    logic [DW-1:0] buf_di;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output buf_din,
        output buf_didx,
        output buf_rw,
        input  buf_di
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  buf_din,
        input  buf_didx,
        input  buf_rw,
        output buf_di
    );

endinterface

// File: rtl/dbuf_rd_pipe.sv
// Two-stage valid shift: one stage for the loader's address register, one for dbuf's read register.
module dbuf_rd_pipe (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic valid
);

    logic vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            valid  <= 1'b0;
        end else begin
            vld_p0 <= go;
            valid  <= vld_p0;
        end
    end

endmodule

// File: rtl/dbuf_loader.sv
// Loads a valid/ready word stream into dbuf from a base address, then serves compute-side reads.
// Define DBUF_LOAD_CSUM_EN to add the csum output (running sum of the accepted words).
module dbuf_loader
    import dbuf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] len,
    input  logic          clear,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic          err,
`ifdef DBUF_LOAD_CSUM_EN
    output logic [DW-1:0] csum,
`endif
    dbuf_loader_if.slave  bus
);

    ld_state_t     state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] base_q;
    logic [AW-1:0] len_q;
    logic          hs;
    logic          last;
    logic          rd_go;
    logic          accept;

    assign hs     = bus.s_valid & bus.s_ready;
    assign last   = (cnt == (len_q - AW'(1)));
    assign rd_go  = rd_en & (state == READY);
    assign accept = (state == IDLE) & start & ((len == '0) | load_fits(base, len));

    // Read data is dbuf's registered output, aligned with rd_valid by the pipe.
    assign rd_data = bus.buf_di;

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            base_q <= base;
            len_q  <= len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.s_ready  <= 1'b0;
            bus.buf_rw   <= 1'b0;
            bus.buf_didx <= '0;
            bus.buf_din  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            err        <= 1'b0;
            bus.buf_rw <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            state <= READY;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                        end else if (!load_fits(base, len)) begin
                            err <= 1'b1;
                        end else begin
                            state       <= LOAD;
                            busy        <= 1'b1;
                            cnt         <= '0;
                            bus.s_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        bus.buf_rw   <= 1'b1;
                        bus.buf_didx <= base_q + cnt;
                        bus.buf_din  <= bus.s_data;
                        cnt          <= cnt + AW'(1);
                        if (last) begin
                            state       <= DRAIN;
                            bus.s_ready <= 1'b0;
                        end
                    end
                end
                // The final write is on the bus during this cycle; dbuf commits it at this edge.
                DRAIN: begin
                    state <= READY;
                    done  <= 1'b1;
                end
                READY: begin
                    if (rd_en) begin
                        bus.buf_didx <= rd_addr;
                    end
                    if (clear) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DBUF_LOAD_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (accept) begin
            csum <= '0;
        end else if (hs) begin
            csum <= csum + bus.s_data;
        end
    end
`endif

    dbuf_rd_pipe u_rd_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (rd_go),
        .valid (rd_valid)
    );

endmodule
